alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Parametrised, registered ALU for the stack datapath, successor to the 16-bit combinational ALU.
//  Single-cycle ops keep their opcodes; adds multi-cycle shifts and optional shift-add multiply.
//  Valid/ready on both sides, so the stack controller can stall on multi-cycle ops.
//  Sits between the top-of-stack registers and stack write-back.
// PARAMETERS
//  WIDTH   16              datapath width in bits (>=4, power of 2)
//  SHW     $clog2(WIDTH)   localparam: shift-amount bits taken from b[SHW-1:0]
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      synchronous reset, active low
//  in_valid   in   1      operation presented on oper/a/b
//  in_ready   out  1      block can accept; transfer when in_valid & in_ready
//  oper       in   4      opcode (table below)
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  out_valid  out  1      result registers valid
//  out_ready  in   1      consumer takes result when out_valid & out_ready
//  alu_out    out  WIDTH  result
//  overflow   out  1      overflow flag for the result
//  err        out  1      illegal or compiled-out opcode was executed
//  busy       out  1      high in BUSY state
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE; alu_out=0, overflow=0, err=0, out_valid=0, busy=0, in_ready=1.
//   Reset mid-operation aborts it; nothing is emitted.
//  Operands and opcode are latched on accept; later changes on a/b/oper have no effect on that op.
//  Opcodes (unsigned compares; arithmetic modulo 2^WIDTH):
//   0000 a+b    0001 a-b    0010 a&b    0011 a|b    0100 a^b    0101 a    0110 b
//   0111 (a==b)?0:1   1000 (a==0)?0:1   1001 (b<a)?1:0
//   1010 a<<b[SHW-1:0] logical   1011 a>>b[SHW-1:0] logical   1100 a*b low WIDTH bits
//   1101-1111 illegal: alu_out=0, overflow=0, err=1
//  overflow: 0000/0001 = signed two's-complement overflow; 1100 = high product half nonzero; else 0.
//  err is 0 for every legal op.
//  FSM IDLE/BUSY/DONE:
//   IDLE: in_ready=1. On accept: single-cycle op or shift count 0 -> DONE next edge (latency 1).
//    Shift count n>0 or 1100 -> BUSY.
//   BUSY: in_ready=0, busy=1. Shifts move one bit per cycle for n cycles.
//    1100 runs WIDTH shift-add iterations. Exits to DONE on the edge after the last iteration.
//    Latency accept->out_valid: shift n+1 cycles, multiply WIDTH+1 cycles.
//   DONE: out_valid=1; alu_out/overflow/err held stable.
//    out_ready=1 -> IDLE on that edge; out_valid drops next cycle.
//  in_ready is 0 in DONE: no accept/retire overlap, so max throughput is one op per 2 cycles.
//  out_ready is ignored outside DONE; in_valid is ignored outside IDLE.
// CONFIGURATION
//  ALU_MUL_EN defined: opcode 1100 is the iterative multiplier described above.
//  ALU_MUL_EN undefined: no multiplier logic; 1100 is treated as illegal
//   (single-cycle, alu_out=0, overflow=0, err=1).
// TESTING
//  1 Reset: hold rst_n=0 2 cycles -> out_valid=0, alu_out=0, in_ready=1, busy=0.
//  2 WIDTH=16, oper=0000, a=16'h7FFF, b=16'h0001
//     -> one cycle later out_valid=1, alu_out=16'h8000, overflow=1, err=0.
//  3 oper=1010, a=16'h0003, b=16'h0004 -> busy 4 cycles, out_valid on 5th, alu_out=16'h0030.
//    Hold out_ready=0 for 3 cycles -> outputs stable, in_ready=0.
//  4 ALU_MUL_EN on, oper=1100, a=16'h0100, b=16'h0100 -> out_valid after 17 cycles,
//     alu_out=16'h0000, overflow=1. With macro off -> alu_out=0, err=1 after 1 cycle.
//  5 oper=1011, a=16'h8000, b=16'h000F; pull rst_n=0 during BUSY
//     -> next cycle IDLE, out_valid=0; new op 0111 a=5 b=5 -> alu_out=0.
//  6 oper=1110 -> alu_out=0, err=1; then oper=1001, a=3, b=2 -> alu_out=1, err=0.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshakes on both sides.
// Single-cycle ops finish one cycle after accept. Shifts move one bit per
// cycle. Opcode 1100 is an iterative shift-add multiplier when ALU_MUL_EN
// is defined; otherwise it is decoded as illegal.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       oper,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             overflow,
  output logic             err,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_A   = 4'b0101;
  localparam logic [3:0] OP_B   = 4'b0110;
  localparam logic [3:0] OP_NEQ = 4'b0111;
  localparam logic [3:0] OP_NZ  = 4'b1000;
  localparam logic [3:0] OP_LT  = 4'b1001;
  localparam logic [3:0] OP_SHL = 4'b1010;
  localparam logic [3:0] OP_SHR = 4'b1011;
`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b1100;
  localparam logic [CW-1:0] MUL_ITERS = CW'(WIDTH);
`endif

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] res_q;
  logic             ovf_q;
  logic             err_q;

  logic [WIDTH-1:0] sum, diff, scRes, shifted;
  logic             scOvf, scErr, needsBusy, lastIter, accept;
  logic [SHW-1:0]   shiftAmt;

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] acc_q, accNext;
  logic [WIDTH:0]     partial;
`endif

  assign sum      = a + b;
  assign diff     = a - b;
  assign shiftAmt = b[SHW-1:0];
  assign accept   = (state_q == IDLE) && in_valid;
  assign lastIter = (cnt_q == CW'(1));
  assign shifted  = (op_q == OP_SHL) ? (a_q << 1) : (a_q >> 1);

  // Result of every op that completes in one cycle, straight from the inputs
  always_comb begin
    scRes = '0;
    scOvf = 1'b0;
    scErr = 1'b0;
    case (oper)
      OP_ADD: begin
        scRes = sum;
        scOvf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        scRes = diff;
        scOvf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:         scRes = a & b;
      OP_OR:          scRes = a | b;
      OP_XOR:         scRes = a ^ b;
      OP_A:           scRes = a;
      OP_B:           scRes = b;
      OP_NEQ:         scRes = {{(WIDTH-1){1'b0}}, (a != b)};
      OP_NZ:          scRes = {{(WIDTH-1){1'b0}}, (a != '0)};
      OP_LT:          scRes = {{(WIDTH-1){1'b0}}, (b < a)};
      OP_SHL, OP_SHR: scRes = a;
      default:        scErr = 1'b1;
    endcase
  end

  // Decide whether the accepted op needs the multi-cycle BUSY phase
  always_comb begin
    needsBusy = ((oper == OP_SHL) || (oper == OP_SHR)) && (shiftAmt != '0);
`ifdef ALU_MUL_EN
    if (oper == OP_MUL) needsBusy = 1'b1;
`endif
  end

`ifdef ALU_MUL_EN
  // One shift-add step: multiplier sits in the low half and drains out LSB first
  always_comb begin
    partial = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    accNext = {partial, acc_q[WIDTH-1:1]};
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = needsBusy ? BUSY : DONE;
      BUSY:    if (lastIter) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the state
  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q == BUSY);
    out_valid = (state_q == DONE);
  end

  assign alu_out  = res_q;
  assign overflow = ovf_q;
  assign err      = err_q;

  // Operand capture, iteration and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q  <= '0;
      a_q   <= '0;
      cnt_q <= '0;
      res_q <= '0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
`ifdef ALU_MUL_EN
      acc_q <= '0;
`endif
    end else if (accept) begin
      op_q  <= oper;
      a_q   <= a;
      cnt_q <= {1'b0, shiftAmt};
`ifdef ALU_MUL_EN
      acc_q <= {{WIDTH{1'b0}}, b};
      if (oper == OP_MUL) cnt_q <= MUL_ITERS;
`endif
      if (needsBusy) begin
        ovf_q <= 1'b0;
        err_q <= 1'b0;
      end else begin
        res_q <= scRes;
        ovf_q <= scOvf;
        err_q <= scErr;
      end
    end else if (state_q == BUSY) begin
      cnt_q <= cnt_q - CW'(1);
`ifdef ALU_MUL_EN
      if (op_q == OP_MUL) begin
        acc_q <= accNext;
        if (lastIter) begin
          res_q <= accNext[WIDTH-1:0];
          ovf_q <= |accNext[2*WIDTH-1:WIDTH];
        end
      end else
`endif
      begin
        a_q <= shifted;
        if (lastIter) res_q <= shifted;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq at WIDTH=16. Expectations are
// pushed when an op is driven and popped when out_valid appears. Builds
// with or without ALU_MUL_EN; the model follows the same macro.
module tb_alu_seq;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] res;
    logic         ovf;
    logic         err;
    int           lat;
    int           busyCyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   oper;
  logic [W-1:0] a, b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] alu_out;
  logic         overflow, err, busy;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .oper(oper), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .alu_out(alu_out), .overflow(overflow), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Every comparison goes through here
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Reference behaviour, written independently with wide integer arithmetic
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] av,
                                 input logic [W-1:0] bv);
    exp_t e;
    int sa, sb2, n;
    longint prod;
    sa = $signed(av);
    sb2 = $signed(bv);
    n = int'(bv[3:0]);
    e.res = '0; e.ovf = 1'b0; e.err = 1'b0; e.lat = 1; e.busyCyc = 0;
    case (op)
      4'd0: begin e.res = W'(sa + sb2); e.ovf = (sa + sb2 > 32767) || (sa + sb2 < -32768); end
      4'd1: begin e.res = W'(sa - sb2); e.ovf = (sa - sb2 > 32767) || (sa - sb2 < -32768); end
      4'd2: e.res = av & bv;
      4'd3: e.res = av | bv;
      4'd4: e.res = av ^ bv;
      4'd5: e.res = av;
      4'd6: e.res = bv;
      4'd7: e.res = (av == bv) ? 16'd0 : 16'd1;
      4'd8: e.res = (av == 0) ? 16'd0 : 16'd1;
      4'd9: e.res = (bv < av) ? 16'd1 : 16'd0;
      4'd10: begin e.res = av << n; e.lat = n + 1; e.busyCyc = n; end
      4'd11: begin e.res = av >> n; e.lat = n + 1; e.busyCyc = n; end
`ifdef ALU_MUL_EN
      4'd12: begin
        prod = longint'(av) * longint'(bv);
        e.res = prod[15:0];
        e.ovf = (prod >> 16) != 0;
        e.lat = W + 1;
        e.busyCyc = W;
      end
`endif
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  // Drive one op at a negedge, push its expectation, scramble inputs after accept
  task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] av,
                               input logic [W-1:0] bv, input int hold);
    checkOutput("in_ready_before", in_ready, 1'b1);
    sb.push_back(model(op, av, bv));
    oper = op; a = av; b = bv;
    in_valid = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    oper = 4'(~op);
    a = W'($urandom);
    b = W'($urandom);
    collectResult(hold);
  endtask

  // Wait for out_valid, pop and compare, optionally stall, then retire
  task automatic collectResult(input int hold);
    exp_t e;
    int cyc = 0;
    int busyCnt = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (busy) busyCnt++;
    end while (!out_valid && cyc < 100);
    e = sb.pop_front();
    checkOutput("out_valid", out_valid, 1'b1);
    checkOutput("latency", cyc, e.lat);
    checkOutput("busy_cycles", busyCnt, e.busyCyc);
    checkOutput("alu_out", alu_out, e.res);
    checkOutput("overflow", overflow, e.ovf);
    checkOutput("err", err, e.err);
    checkOutput("in_ready_done", in_ready, 1'b0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("hold_valid", out_valid, 1'b1);
      checkOutput("hold_out", alu_out, e.res);
      checkOutput("hold_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("retired", out_valid, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    oper = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_alu_out", alu_out, 16'h0000);
    checkOutput("rst_in_ready", in_ready, 1'b1);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_err", err, 1'b0);
    checkOutput("rst_overflow", overflow, 1'b0);
    rst_n = 1'b1;

    applyStimulus(4'b0000, 16'h7FFF, 16'h0001, 0);
    applyStimulus(4'b1010, 16'h0003, 16'h0004, 3);
    applyStimulus(4'b1100, 16'h0100, 16'h0100, 0);
    applyStimulus(4'b1100, 16'h0007, 16'h0009, 1);
    applyStimulus(4'b0001, 16'h8000, 16'h0001, 0);
    applyStimulus(4'b1011, 16'hF000, 16'h0010, 0);
    applyStimulus(4'b1010, 16'h0001, 16'h000F, 0);
    applyStimulus(4'b1110, 16'h1234, 16'h5678, 0);
    applyStimulus(4'b1001, 16'h0003, 16'h0002, 0);
    applyStimulus(4'b1000, 16'h0000, 16'h0000, 0);

    // Reset in the middle of a long shift aborts it with nothing emitted
    oper = 4'b1011; a = 16'h8000; b = 16'h000F; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("abort_busy", busy, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_out_valid", out_valid, 1'b0);
    checkOutput("abort_busy_low", busy, 1'b0);
    checkOutput("abort_in_ready", in_ready, 1'b1);
    checkOutput("abort_alu_out", alu_out, 16'h0000);
    rst_n = 1'b1;
    applyStimulus(4'b0111, 16'h0005, 16'h0005, 0);

    for (int i = 0; i < 24; i++) begin
      applyStimulus(4'($urandom_range(0, 15)), W'($urandom), W'($urandom),
                    int'($urandom_range(0, 2)));
    end

    checkOutput("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
